// File: rtl/peripheral_interco_pkg.sv
// Shared definitions for the peripheral interconnect: pointer/count width
// helpers and the response payload type.
package peripheral_interco_pkg;

    localparam int RESP_DATA_W = 32;

    // A depth-1 FIFO still needs a 1-bit pointer to index its single slot.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [RESP_DATA_W-1:0] rdata;
        logic                   opc;
    } resp_t;

endpackage

// File: rtl/generic_id_fifo.sv
// In-order FIFO with occupancy count; pushes while full and pops while empty
// are ignored, so callers may present unqualified requests.
module generic_id_fifo
    import peripheral_interco_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (r_count == CNT_W'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign rdata_o   = r_mem[r_rptr];
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/response_router_pe.sv
// Slave-side response router: remembers granted request IDs in order and
// steers each peripheral response back to its originating master.
module response_router_pe
    import peripheral_interco_pkg::*;
#(
    parameter int N_MASTER        = 8,
    parameter int ID_WIDTH        = N_MASTER,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    output logic                  data_gnt_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_r_valid_i,
    input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
    input  logic                  data_r_opc_i,
    output logic [N_MASTER-1:0]   data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                  data_r_opc_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  err_unexp_o
);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [ID_WIDTH-1:0]   w_head_id;
    logic [N_MASTER-1:0]   r_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_opc;
    logic                  r_err;

    // Full comes from registered occupancy only, so a pop never frees a
    // slot for a push in the same cycle.
    assign data_req_o = data_req_i & ~w_full;
    assign data_gnt_o = data_gnt_i & ~w_full;
    assign w_push     = data_req_i & data_gnt_i & ~w_full;
    assign w_pop      = data_r_valid_i & ~w_empty;

    generic_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_WIDTH),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .wdata_i (data_ID_i),
        .pop_i   (w_pop),
        .rdata_o (w_head_id),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (outstanding_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_rdata <= '0;
            r_opc   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_pop ? w_head_id : '0;
            r_err   <= data_r_valid_i & w_empty;
            if (w_pop) begin
                r_rdata <= data_r_rdata_i;
                r_opc   <= data_r_opc_i;
            end
        end
    end

    assign data_r_valid_o = r_valid;
    assign data_r_rdata_o = r_rdata;
    assign data_r_opc_o   = r_opc;
    assign err_unexp_o    = r_err;

    a_push_id_onehot0 : assert property (
        @(posedge clk) disable iff (!rst_n) w_push |-> $onehot0(data_ID_i)
    );

endmodule

// File: tb/tb_response_router_pe.sv
// Self-checking bench for response_router_pe against a queue-based model.
module tb_response_router_pe;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int MAX = 4;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic [N-1:0]  id = '0;
    logic          gnt = 1'b0;
    logic          rv = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          opc = 1'b0;
    logic          gnt_o;
    logic          req_o;
    logic [N-1:0]  valid_o;
    logic [DW-1:0] rdata_o;
    logic          opc_o;
    logic [CW-1:0] outst_o;
    logic          err_o;

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0]  q[$];
    logic [N-1:0]  exp_valid = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_opc = 1'b0;
    logic          exp_err = 1'b0;

    response_router_pe #(
        .N_MASTER(N), .ID_WIDTH(N), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req), .data_ID_i(id), .data_gnt_o(gnt_o),
        .data_req_o(req_o), .data_gnt_i(gnt),
        .data_r_valid_i(rv), .data_r_rdata_i(rdata), .data_r_opc_i(opc),
        .data_r_valid_o(valid_o), .data_r_rdata_o(rdata_o), .data_r_opc_o(opc_o),
        .outstanding_o(outst_o), .err_unexp_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic idle();
        req = 1'b0; gnt = 1'b0; id = '0; rv = 1'b0; rdata = '0; opc = 1'b0;
    endtask

    task automatic model_clear();
        q.delete();
        exp_valid = '0; exp_rdata = '0; exp_opc = 1'b0; exp_err = 1'b0;
    endtask

    // Advance one clock; the model applies the outstanding-list rules to the
    // inputs presented during the cycle that is ending.
    task automatic tick();
        int  sz;
        bit  full;
        sz   = q.size();
        full = (sz == MAX);
        if (rv && sz > 0) begin
            exp_valid = q.pop_front();
            exp_rdata = rdata;
            exp_opc   = opc;
        end else begin
            exp_valid = '0;
        end
        exp_err = rv && (sz == 0);
        if (req && gnt && !full) q.push_back(id);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        #3;
        vectors++;
        if (outst_o !== 3'd0 || valid_o !== 8'h00 || err_o !== 1'b0 ||
            rdata_o !== 32'h0 || opc_o !== 1'b0 || req_o !== 1'b0 || gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: outst=%0d valid=%h err=%b rdata=%h opc=%b req_o=%b gnt_o=%b, all zero required",
                     outst_o, valid_o, err_o, rdata_o, opc_o, req_o, gnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        req = 1'b1; gnt = 1'b1; id = 8'b0000_0100;
        tick();
        idle();
        vectors++;
        if (outst_o !== 3'd1) begin
            miscompares++;
            $display("FAIL single_outst1: got %0d expected 1", outst_o);
        end
        tick();
        rv = 1'b1; rdata = 32'hDEADBEEF;
        tick();
        idle();
        vectors++;
        if (valid_o !== 8'b0000_0100 || rdata_o !== 32'hDEADBEEF || outst_o !== 3'd0) begin
            miscompares++;
            $display("FAIL single_resp: valid=%h rdata=%h outst=%0d expected 04 DEADBEEF 0",
                     valid_o, rdata_o, outst_o);
        end
        tick();
        vectors++;
        if (valid_o !== 8'h00 || rdata_o !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_hold: valid=%h rdata=%h expected 00 DEADBEEF", valid_o, rdata_o);
        end
    endtask

    task automatic test_ordering();
        logic [N-1:0]  ids[3];
        logic [DW-1:0] dat[3];
        ids = '{8'h01, 8'h80, 8'h10};
        dat = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; gnt = 1'b1; id = ids[i];
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            rv = 1'b1; rdata = dat[i]; opc = i[0];
            tick();
            vectors++;
            if (valid_o !== ids[i] || rdata_o !== dat[i] || opc_o !== i[0]) begin
                miscompares++;
                $display("FAIL order_%0d: valid=%h rdata=%h opc=%b expected %h %h %b",
                         i, valid_o, rdata_o, opc_o, ids[i], dat[i], i[0]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_full_throttle();
        for (int i = 0; i < MAX; i++) begin
            req = 1'b1; gnt = 1'b1; id = 8'h01 << i;
            tick();
        end
        vectors++;
        if (outst_o !== 3'd4 || gnt_o !== 1'b0 || req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_gate: outst=%0d gnt_o=%b req_o=%b expected 4 0 0", outst_o, gnt_o, req_o);
        end
        id = 8'h40; rv = 1'b1; rdata = 32'h1234_5678;
        tick();
        vectors++;
        if (outst_o !== 3'd3 || valid_o !== 8'h01 || gnt_o !== 1'b1 || req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL full_release: outst=%0d valid=%h gnt_o=%b req_o=%b expected 3 01 1 1",
                     outst_o, valid_o, gnt_o, req_o);
        end
        rv = 1'b0;
        tick();
        idle();
        vectors++;
        if (outst_o !== 3'd4) begin
            miscompares++;
            $display("FAIL full_refill: outst=%0d expected 4", outst_o);
        end
        for (int i = 0; i < MAX; i++) begin
            rv = 1'b1; rdata = $urandom;
            tick();
            vectors++;
            if (valid_o !== exp_valid || rdata_o !== exp_rdata) begin
                miscompares++;
                $display("FAIL full_drain_%0d: valid=%h rdata=%h expected %h %h",
                         i, valid_o, rdata_o, exp_valid, exp_rdata);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_simul_push_pop();
        req = 1'b1; gnt = 1'b1; id = 8'h20;
        tick();
        id = 8'h40;
        tick();
        id = 8'h02; rv = 1'b1; rdata = 32'hCAFE_0001;
        tick();
        idle();
        vectors++;
        if (outst_o !== 3'd2 || valid_o !== 8'h20) begin
            miscompares++;
            $display("FAIL simul_pushpop: outst=%0d valid=%h expected 2 20", outst_o, valid_o);
        end
        rv = 1'b1;
        tick();
        vectors++;
        if (valid_o !== 8'h40) begin
            miscompares++;
            $display("FAIL simul_next1: valid=%h expected 40", valid_o);
        end
        tick();
        idle();
        vectors++;
        if (valid_o !== 8'h02 || outst_o !== 3'd0) begin
            miscompares++;
            $display("FAIL simul_next2: valid=%h outst=%0d expected 02 0", valid_o, outst_o);
        end
        tick();
    endtask

    task automatic test_unexpected();
        rv = 1'b1; rdata = 32'h5555_AAAA;
        tick();
        idle();
        vectors++;
        if (err_o !== 1'b1 || valid_o !== 8'h00 || outst_o !== 3'd0) begin
            miscompares++;
            $display("FAIL unexp_pulse: err=%b valid=%h outst=%0d expected 1 00 0", err_o, valid_o, outst_o);
        end
        tick();
        vectors++;
        if (err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL unexp_one_cycle: err=%b expected 0", err_o);
        end
        req = 1'b1; gnt = 1'b1; id = 8'h08; rv = 1'b1;
        tick();
        idle();
        vectors++;
        if (err_o !== 1'b1 || valid_o !== 8'h00 || outst_o !== 3'd1) begin
            miscompares++;
            $display("FAIL unexp_push_empty: err=%b valid=%h outst=%0d expected 1 00 1", err_o, valid_o, outst_o);
        end
        rv = 1'b1;
        tick();
        idle();
        vectors++;
        if (valid_o !== 8'h08 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL unexp_then_pop: valid=%h err=%b expected 08 0", valid_o, err_o);
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; gnt = 1'b1; id = 8'h01 << (i + 2);
            tick();
        end
        id = 8'h80; rv = 1'b1; rdata = 32'hFFFF_0000; opc = 1'b1;
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (outst_o !== 3'd0 || valid_o !== 8'h00 || rdata_o !== 32'h0 || opc_o !== 1'b0 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: outst=%0d valid=%h rdata=%h opc=%b err=%b expected all zero",
                     outst_o, valid_o, rdata_o, opc_o, err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rv = 1'b1; rdata = 32'h0BAD_0BAD;
        tick();
        idle();
        vectors++;
        if (err_o !== 1'b1 || valid_o !== 8'h00 || outst_o !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_then_resp: err=%b valid=%h outst=%0d expected 1 00 0", err_o, valid_o, outst_o);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req   = ($urandom_range(0, 99) < 60);
            gnt   = ($urandom_range(0, 99) < 70);
            id    = 8'h01 << $urandom_range(0, N - 1);
            rv    = ($urandom_range(0, 99) < 45);
            rdata = $urandom;
            opc   = $urandom_range(0, 1);
            #1;
            vectors++;
            if (req_o !== (req && q.size() != MAX) || gnt_o !== (gnt && q.size() != MAX)) begin
                miscompares++;
                $display("FAIL rand_gate cyc%0d: req_o=%b gnt_o=%b occ=%0d req=%b gnt=%b",
                         c, req_o, gnt_o, q.size(), req, gnt);
            end
            tick();
            vectors++;
            if (valid_o !== exp_valid || rdata_o !== exp_rdata || opc_o !== exp_opc ||
                err_o !== exp_err || outst_o !== CW'(q.size())) begin
                miscompares++;
                $display("FAIL rand_out cyc%0d: valid=%h rdata=%h opc=%b err=%b outst=%0d expected %h %h %b %b %0d",
                         c, valid_o, rdata_o, opc_o, err_o, outst_o,
                         exp_valid, exp_rdata, exp_opc, exp_err, q.size());
            end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_ordering();
        test_full_throttle();
        test_simul_push_pop();
        test_unexpected();
        test_async_reset();
        do_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/response_router_pe.md
Name: response_router_pe

Overview:
- Response-side counterpart of the peripheral-interconnect request fan-in tree.
- Sits at one slave port, between the root of the request arbitration tree and the peripheral.
- Records the ID of every granted request in an in-order outstanding FIFO.
- On each peripheral response, pops the oldest ID and steers r_valid, r_rdata and r_opc back to the originating master, one cycle later. Also throttles the request/grant path when the outstanding budget is exhausted.

Parameters:
- N_MASTER, 8, number of masters; ID is one-hot of this width.
- ID_WIDTH, N_MASTER, width of the request ID; must equal N_MASTER.
- DATA_WIDTH, 32, response data width.
- MAX_OUTSTANDING, 4, outstanding-ID FIFO depth; power of two, at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_req_i  in  1  request from the arbitration tree root.
- data_ID_i  in  ID_WIDTH  one-hot ID of the winning request.
- data_gnt_o  out  1  grant back into the arbitration tree.
- data_req_o  out  1  request to the peripheral.
- data_gnt_i  in  1  grant from the peripheral.
- data_r_valid_i  in  1  response valid from the peripheral.
- data_r_rdata_i  in  DATA_WIDTH  response data.
- data_r_opc_i  in  1  response error/opcode bit.
- data_r_valid_o  out  N_MASTER  per-master response valid, one-hot.
- data_r_rdata_o  out  DATA_WIDTH  response data, shared bus.
- data_r_opc_o  out  1  response opcode, shared.
- outstanding_o  out  clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- err_unexp_o  out  1  one-cycle pulse when a response arrives with no outstanding ID.

Behaviour:
- Reset (async, rst_n=0) clears:
  - FIFO read/write pointers and occupancy to 0.
  - data_r_valid_o, data_r_rdata_o, data_r_opc_o, err_unexp_o.
  - Effect on gating outputs: data_req_o and data_gnt_o read 0, because they are combinational gating of their inputs and not-full.
- Full flag:
  - full = (occupancy == MAX_OUTSTANDING).
  - Derived from registered state only; never from data_r_valid_i in the same cycle.
- Request gating (combinational):
  - data_req_o = data_req_i & ~full.
  - data_gnt_o = data_gnt_i & ~full.
- Push:
  - Condition: data_req_i & data_gnt_i & ~full.
  - data_ID_i is written at the write pointer; write pointer increments, wrapping modulo MAX_OUTSTANDING.
- Pop:
  - Condition: data_r_valid_i & ~empty.
  - The ID at the read pointer is consumed; read pointer increments with wrap.
- Simultaneous push and pop:
  - Both happen in the same cycle; occupancy is unchanged.
  - Pop reads the old head.
  - Push while empty with r_valid in the same cycle is not a pop: the response is unexpected.
- Full with pop in the same cycle: the push is still blocked that cycle, since full is registered. New grants resume the next cycle.
- Response output, latency 1 cycle registered:
  - On a pop, next cycle: data_r_valid_o = popped ID (one-hot), data_r_rdata_o = data_r_rdata_i, data_r_opc_o = data_r_opc_i.
  - Without a pop, data_r_valid_o = 0.
  - rdata and opc hold their previous values; only valid is qualified.
- Unexpected response:
  - Condition: data_r_valid_i while empty.
  - Response is dropped; data_r_valid_o stays 0.
  - err_unexp_o = 1 for exactly the next cycle; FIFO state unchanged.
- ID integrity: a pushed ID that is not one-hot is stored and returned verbatim. Checking is an SVA assertion (onehot0 on push), not RTL.
- Ordering: responses are returned strictly in grant order. The peripheral must answer in order.
- outstanding_o is the registered occupancy; it never exceeds MAX_OUTSTANDING.
- Reset mid-operation: all outstanding IDs are discarded. Responses arriving after reset release are reported via err_unexp_o.

Decomposition:
- Shared package peripheral_interco_pkg holds:
  - localparam functions for the pointer/count widths (clog2).
  - The response struct typedef {rdata, opc}.
- One natural sub-module: generic_id_fifo (depth, width, push/pop/full/empty/count, async active-low reset). Instantiated once for the outstanding IDs.
- The router wraps it with gating, output registers and error logic.

Test Plan:
- Single read: req=1, gnt_i=1, ID=8'b0000_0100 at cycle 0; r_valid_i=1, rdata=0xDEADBEEF at cycle 2 -> cycle 3: r_valid_o=8'b0000_0100, rdata_o=0xDEADBEEF; outstanding_o goes 1 then 0.
- Ordering: grants with IDs 0x01, 0x80, 0x10 on consecutive cycles; responses 0xA, 0xB, 0xC -> r_valid_o sequence 0x01, 0x80, 0x10 paired with 0xA, 0xB, 0xC.
- Full throttle (MAX_OUTSTANDING=4): 4 grants with no responses -> outstanding_o=4; data_gnt_o=0 and data_req_o=0 while data_req_i=1, gnt_i=1. One response -> gating releases one cycle after the pop.
- Simultaneous push/pop at occupancy 2: push ID 0x02 and pop in the same cycle -> occupancy stays 2; the returned ID is the old head, not 0x02.
- Unexpected response at empty: r_valid_i=1 -> next cycle err_unexp_o=1 for 1 cycle, r_valid_o=0, outstanding_o=0.
- Async reset at occupancy 3: rst_n low mid-cycle -> outputs 0 immediately. After release, r_valid_i=1 -> err_unexp_o pulse and no r_valid_o.
